// File: rtl/multi_mainfsm_if.sv
// Control bus between the multicycle ARM main FSM and the rest of the controller.
// The master drives the instruction fields and the memory handshake; the slave is the FSM.
interface multi_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic [3:0] State;

  modport master (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );

  modport slave (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );
endinterface

// File: rtl/multi_mainfsm.sv
// Main control FSM of the multicycle ARM core: sequences fetch, decode, execute and
// writeback over the shared datapath, with an optional memory-ready stall.
module multi_mainfsm #(
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  multi_mainfsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  typedef struct packed {
    logic       fetch;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctl_t;

  // Moore control word for a state; illegal codes yield all zeros.
  function automatic ctl_t decode_ctl(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b01;
      end
      S_MEMRD: begin
        c.adr_src    = 1'b1;
        c.result_src = 2'b00;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src    = 1'b1;
        c.result_src = 2'b00;
        c.mem_w      = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b00;
        c.alu_op     = 1'b1;
      end
      S_EXECI: begin
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b01;
        c.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = 2'b00;
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q;
  state_e state_d;
  ctl_t   ctl_q;
  logic   rdy_s;
  logic   unused_funct_s;

  assign rdy_s          = MEM_WAIT ? bus.MemReady : 1'b1;
  assign unused_funct_s = ^bus.Funct[4:1];

  // Next-state selection; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = rdy_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = rdy_s ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy_s ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB:  state_d = S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State and control word registered together so outputs stay aligned with State.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode_ctl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d);
    end
  end

  // The fetch strobes follow the live handshake and are held off while in reset.
  assign bus.IRWrite   = ctl_q.fetch & rdy_s & reset;
  assign bus.NextPC    = ctl_q.fetch & rdy_s & reset;
  assign bus.AdrSrc    = ctl_q.adr_src;
  assign bus.ALUSrcA   = ctl_q.alu_src_a;
  assign bus.ALUSrcB   = ctl_q.alu_src_b;
  assign bus.ResultSrc = ctl_q.result_src;
  assign bus.ALUOp     = ctl_q.alu_op;
  assign bus.RegW      = ctl_q.reg_w;
  assign bus.MemW      = ctl_q.mem_w;
  assign bus.Branch    = ctl_q.branch;
  assign bus.State     = state_q;

endmodule
